// File: rtl/des_pkg.sv
// des_pkg: DES tables (FIPS 46 bit numbering, 1 = MSB), permutation/S-box
// helpers and the core FSM state type. When DES_ITER_TDES_EN is defined the
// key is three concatenated DES keys (K1 in the MSBs).
package des_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef DES_ITER_TDES_EN
   localparam int KEY_W = 192;
`else
   localparam int KEY_W = 64;
`endif

   localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   // SHIFT[i] is the key rotation for round i+1
   localparam int SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   localparam int SBOX [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

   function automatic logic [63:0] f_ip(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
      return y;
   endfunction

   function automatic logic [63:0] f_fp(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
      return y;
   endfunction

   function automatic logic [55:0] f_pc1(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
      return y;
   endfunction

   function automatic logic [47:0] f_pc2(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
      return y;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   // Outer bits of the 6-bit chunk pick the row, inner four the column
   function automatic logic [3:0] sbox(input logic [2:0] idx, input logic [5:0] b);
      return 4'(SBOX[idx][{b[5], b[0], b[4:1]}]);
   endfunction

   function automatic logic [31:0] f_feistel(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [47:0] e;
      logic [31:0] s;
      logic [31:0] p;
      e = '0;
      for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[i])];
      x = e ^ k;
      s = '0;
      for (int i = 0; i < 8; i++) s[5'(28 - 4 * i) +: 4] = sbox(3'(i), x[6'(42 - 6 * i) +: 6]);
      p = '0;
      for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_T[i])];
      return p;
   endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational Feistel round with its on-the-fly key schedule step.
// Encrypt rotates left before PC2; decrypt uses PC2 first, then rotates right,
// so C/D walk back to their PC1 value after 16 rounds in either direction.
module des_round
   import des_pkg::*;
(
   input  logic [31:0] l_i,
   input  logic [31:0] r_i,
   input  logic [27:0] c_i,
   input  logic [27:0] d_i,
   input  logic        enc_i,
   input  logic [3:0]  rnd_i,
   output logic [31:0] l_o,
   output logic [31:0] r_o,
   output logic [27:0] c_o,
   output logic [27:0] d_o
);
   logic        two;
   logic [47:0] subkey;

   // Select the rotation amount, derive the subkey and advance C/D
   always_comb begin
      two = enc_i ? (SHIFT[rnd_i] == 2) : (SHIFT[4'd15 - rnd_i] == 2);
      if (enc_i) begin
         c_o    = rotl28(c_i, two);
         d_o    = rotl28(d_i, two);
         subkey = f_pc2({c_o, d_o});
      end else begin
         subkey = f_pc2({c_i, d_i});
         c_o    = rotr28(c_i, two);
         d_o    = rotr28(d_i, two);
      end
      l_o = r_i;
      r_o = l_i ^ f_feistel(r_i, subkey);
   end
endmodule

// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES engine, ROUNDS_PER_CYCLE rounds per clock,
// valid/ready on both sides. Define DES_ITER_TDES_EN for 192-bit keys and
// triple-DES EDE over three passes.
module des_iter_core
   import des_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             enc1_dec0,
   input  logic [63:0]      in,
   input  logic [KEY_W-1:0] key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out
);
   localparam int NCYC = 16 / ROUNDS_PER_CYCLE;
   localparam logic [3:0] LAST_CYC = 4'(NCYC - 1);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
         ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
      $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   state_t      state_q, state_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic [63:0] out_q, out_d;
   logic [31:0] l_q, l_d, r_q, r_d;
   logic [27:0] c_q, c_d, d_q, d_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        enc_q, enc_d;
   logic        rnd_enc;
   logic        last_pass;
   logic [63:0] first_key;

`ifdef DES_ITER_TDES_EN
   logic [1:0]   pass_q, pass_d;
   logic [191:0] key_q, key_d;

   // Encrypt walks K1,K2,K3; decrypt walks K3,K2,K1. K1 is in the MSBs.
   function automatic logic [63:0] pass_key(input logic [191:0] k, input logic enc,
                                            input logic [1:0] p);
      logic [1:0] idx;
      idx = enc ? p : 2'd2 - p;
      case (idx)
         2'd0:    return k[191:128];
         2'd1:    return k[127:64];
         default: return k[63:0];
      endcase
   endfunction

   assign rnd_enc   = enc_q ^ (pass_q == 2'd1);
   assign last_pass = (pass_q == 2'd2);
   assign first_key = pass_key(key, enc1_dec0, 2'd0);
`else
   assign rnd_enc   = enc_q;
   assign last_pass = 1'b1;
   assign first_key = key;
`endif

   logic [31:0] l_c [ROUNDS_PER_CYCLE+1];
   logic [31:0] r_c [ROUNDS_PER_CYCLE+1];
   logic [27:0] c_c [ROUNDS_PER_CYCLE+1];
   logic [27:0] d_c [ROUNDS_PER_CYCLE+1];

   assign l_c[0] = l_q;
   assign r_c[0] = r_q;
   assign c_c[0] = c_q;
   assign d_c[0] = d_q;

   for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
      des_round u_round (
         .l_i  (l_c[gi]),
         .r_i  (r_c[gi]),
         .c_i  (c_c[gi]),
         .d_i  (d_c[gi]),
         .enc_i(rnd_enc),
         .rnd_i(4'(int'(cnt_q) * ROUNDS_PER_CYCLE + gi)),
         .l_o  (l_c[gi+1]),
         .r_o  (r_c[gi+1]),
         .c_o  (c_c[gi+1]),
         .d_o  (d_c[gi+1])
      );
   end

   // Next-state logic for the IDLE/RUN/DONE controller and datapath
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      l_d         = l_q;
      r_d         = r_q;
      c_d         = c_q;
      d_d         = d_q;
      cnt_d       = cnt_q;
      enc_d       = enc_q;
`ifdef DES_ITER_TDES_EN
      pass_d      = pass_q;
      key_d       = key_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               enc_d      = enc1_dec0;
               {l_d, r_d} = f_ip(in);
               {c_d, d_d} = f_pc1(first_key);
               cnt_d      = '0;
`ifdef DES_ITER_TDES_EN
               pass_d     = 2'd0;
               key_d      = key;
`endif
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            l_d   = l_c[ROUNDS_PER_CYCLE];
            r_d   = r_c[ROUNDS_PER_CYCLE];
            c_d   = c_c[ROUNDS_PER_CYCLE];
            d_d   = d_c[ROUNDS_PER_CYCLE];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_CYC) begin
               cnt_d = '0;
               if (!last_pass) begin
`ifdef DES_ITER_TDES_EN
                  // FP then IP cancel between passes: just swap halves, load next key
                  l_d        = r_c[ROUNDS_PER_CYCLE];
                  r_d        = l_c[ROUNDS_PER_CYCLE];
                  {c_d, d_d} = f_pc1(pass_key(key_q, enc_q, pass_q + 2'd1));
                  pass_d     = pass_q + 2'd1;
`endif
               end else begin
                  out_d       = f_fp({r_c[ROUNDS_PER_CYCLE], l_c[ROUNDS_PER_CYCLE]});
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   // State registers; reset aborts any block in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         l_q         <= '0;
         r_q         <= '0;
         c_q         <= '0;
         d_q         <= '0;
         cnt_q       <= '0;
         enc_q       <= 1'b0;
`ifdef DES_ITER_TDES_EN
         pass_q      <= '0;
         key_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         l_q         <= l_d;
         r_q         <= r_d;
         c_q         <= c_d;
         d_q         <= d_d;
         cnt_q       <= cnt_d;
         enc_q       <= enc_d;
`ifdef DES_ITER_TDES_EN
         pass_q      <= pass_d;
         key_q       <= key_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out       = out_q;
endmodule

// File: tb/tb_des_iter_core.sv
// tb_des_iter_core: directed bench over five cores (RPC 1,2,4,8,16) sharing
// data/key/out_ready, with a queue of expected results popped at out_valid.
`timescale 1ns/1ps
module tb_des_iter_core;
   import des_pkg::*;

   localparam int NDUT = 5;
   localparam int RPCS [NDUT] = '{1, 2, 4, 8, 16};
`ifdef DES_ITER_TDES_EN
   localparam int NPASS = 3;
`else
   localparam int NPASS = 1;
`endif

   localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
   localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
   localparam logic [63:0] CT  = 64'h85E813540F0AB405;
   localparam logic [63:0] PT2 = 64'h8787878787878787;
   localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NDUT-1:0]  in_valid_s;
   logic [NDUT-1:0]  in_ready_s;
   logic [NDUT-1:0]  out_valid_s;
   logic             enc1_dec0;
   logic [63:0]      din;
   logic [KEY_W-1:0] key_s;
   logic             out_ready;
   logic [63:0]      out_s [NDUT];

   int checks = 0;
   int errors = 0;
   logic [63:0] sb_q [$];

   // Free-running clock
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      des_iter_core #(.ROUNDS_PER_CYCLE(RPCS[gi])) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid_s[gi]),
         .in_ready (in_ready_s[gi]),
         .enc1_dec0(enc1_dec0),
         .in       (din),
         .key      (key_s),
         .out_valid(out_valid_s[gi]),
         .out_ready(out_ready),
         .out      (out_s[gi])
      );
   end

   function automatic logic [KEY_W-1:0] mk3(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c);
`ifdef DES_ITER_TDES_EN
      return {a, b, c};
`else
      return KEY_W'(a ^ (b & 64'h0) ^ (c & 64'h0));
`endif
   endfunction

   function automatic logic [KEY_W-1:0] mk_key(input logic [63:0] k);
      return mk3(k, k, k);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered and left #1 after a rising edge; out_ready is assumed high.
   task automatic run_block(input int idx, input logic enc, input logic [63:0] blk,
                            input logic [KEY_W-1:0] k, input bit has_exp,
                            input logic [63:0] expv, input string tag,
                            output logic [63:0] got);
      int lat;
      bit seen;
      logic [63:0] e;
      chk({tag, " in_ready"}, 64'(in_ready_s[idx]), 64'd1);
      if (has_exp) sb_q.push_back(expv);
      enc1_dec0       = enc;
      din             = blk;
      key_s           = k;
      in_valid_s[idx] = 1'b1;
      @(posedge clk); #1;
      in_valid_s[idx] = 1'b0;
      // Inputs outside IDLE must be ignored
      din       = {$urandom, $urandom};
      key_s     = mk3({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      enc1_dec0 = ~enc;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid_s[idx]) seen = 1'b1;
      end
      chk({tag, " latency"}, 64'(lat), 64'(NPASS * 16 / RPCS[idx]));
      got = out_s[idx];
      if (has_exp) begin
         e = sb_q.pop_front();
         chk({tag, " out"}, out_s[idx], e);
      end
      @(posedge clk); #1;
      chk({tag, " done one cycle"}, 64'(out_valid_s[idx]), 64'd0);
      chk({tag, " back to idle"}, 64'(in_ready_s[idx]), 64'd1);
      $display("block %s rpc=%0d enc=%0b in=%h out=%h latency=%0d", tag, RPCS[idx], enc, blk, got, lat);
   endtask

   // Hard stop if anything hangs
   initial begin
      #2ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Directed sequence
   initial begin
      int lat;
      bit seen;
      logic [63:0] got, ct, pt, ka, kb, kc, e;

      rst_n      = 1'b0;
      in_valid_s = '0;
      enc1_dec0  = 1'b1;
      din        = '0;
      key_s      = '0;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NDUT; i++) begin
         chk($sformatf("reset in_ready %0d", i), 64'(in_ready_s[i]), 64'd1);
         chk($sformatf("reset out_valid %0d", i), 64'(out_valid_s[i]), 64'd0);
         chk($sformatf("reset out %0d", i), out_s[i], 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Known-answer vectors across all round widths
      run_block(0, 1'b1, PT, mk_key(K1), 1'b1, CT, "enc rpc1", got);
      run_block(2, 1'b0, CT, mk_key(K1), 1'b1, PT, "dec rpc4", got);
      run_block(1, 1'b1, PT, mk_key(K1), 1'b1, CT, "enc rpc2", got);
      run_block(3, 1'b1, PT, mk_key(K1), 1'b1, CT, "enc rpc8", got);
      run_block(4, 1'b1, PT, mk_key(K1), 1'b1, CT, "enc rpc16", got);
      run_block(0, 1'b1, PT2, mk_key(K2), 1'b1, 64'h0, "enc zero", got);
      run_block(4, 1'b0, 64'h0, mk_key(K2), 1'b1, PT2, "dec zero", got);
      run_block(0, 1'b1, PT, mk_key(K1), 1'b1, CT, "enc rpc1 again", got);

      // Backpressure: in_valid held during RUN/DONE, out_ready low in DONE
      out_ready = 1'b0;
      sb_q.push_back(CT);
      enc1_dec0     = 1'b1;
      din           = PT;
      key_s         = mk_key(K1);
      in_valid_s[0] = 1'b1;
      @(posedge clk); #1;
      din       = 64'hFEDCBA9876543210;
      key_s     = mk_key(64'hFFFFFFFFFFFFFFFF);
      enc1_dec0 = 1'b0;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid_s[0]) seen = 1'b1;
         else chk("bp in_ready run", 64'(in_ready_s[0]), 64'd0);
      end
      chk("bp latency", 64'(lat), 64'(NPASS * 16));
      e = sb_q.pop_front();
      chk("bp out", out_s[0], e);
      for (int c = 0; c < 10; c++) begin
         in_valid_s[0] = (c % 2 == 0);
         @(posedge clk); #1;
         chk("bp hold out", out_s[0], e);
         chk("bp hold valid", 64'(out_valid_s[0]), 64'd1);
         chk("bp hold in_ready", 64'(in_ready_s[0]), 64'd0);
      end
      in_valid_s[0] = 1'b0;
      out_ready     = 1'b1;
      @(posedge clk); #1;
      chk("bp release valid", 64'(out_valid_s[0]), 64'd0);
      chk("bp release in_ready", 64'(in_ready_s[0]), 64'd1);
      chk("bp out kept", out_s[0], e);
      $display("block backpressure rpc=1 out=%h latency=%0d", out_s[0], lat);

      // Reset in the middle of RUN
      enc1_dec0     = 1'b1;
      din           = PT2;
      key_s         = mk_key(K2);
      in_valid_s[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_s[0] = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst mid out_valid", 64'(out_valid_s[0]), 64'd0);
      chk("rst mid out", out_s[0], 64'd0);
      chk("rst mid in_ready", 64'(in_ready_s[0]), 64'd1);
      $display("reset mid-run out=%h in_ready=%0b", out_s[0], in_ready_s[0]);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_block(0, 1'b1, PT, mk_key(K1), 1'b1, CT, "after reset", got);

      // Round trips with random (distinct under TDES) keys
      for (int t = 0; t < 4; t++) begin
         pt = {$urandom, $urandom};
         ka = {$urandom, $urandom};
         kb = {$urandom, $urandom};
         kc = {$urandom, $urandom};
         run_block(t % NDUT, 1'b1, pt, mk3(ka, kb, kc), 1'b0, 64'h0, "rt enc", ct);
         run_block((t + 2) % NDUT, 1'b0, ct, mk3(ka, kb, kc), 1'b1, pt, "rt dec", got);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
